uart_transmit_controller: RTL and testbench

Serialises bytes onto the UART TX pin as 8N1 frames: one start bit, eight data bits LSB first, one stop bit. This is the transmit-side counterpart of the UART receive controller and shares its bit timing. A small FIFO decouples the producer (host-response / debug logic) from the line rate. Sits at the top level next to the receive controller, driving the board's UART TX pin.

---
 rtl/uart_transmit_controller.sv | 140 ++++++++++++++
 tb/tb_uart_transmit_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit_controller.sv
// 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop bit serialiser.
// Each bit is held for CLOCK_RATE clocks. Frames go back to back while Enable is high and bytes are queued.
module uart_transmit_controller #(
  parameter int CLOCK_RATE = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Load_data,
  input  logic [7:0] TX_data,
  output logic       Full,
  output logic       Empty,
  output logic       Busy,
  output logic       Overflow,
  output logic       UART_TX_O
);

  localparam int CNT_W = ($clog2(CLOCK_RATE) > 10) ? $clog2(CLOCK_RATE) : 10;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCK_RATE - 1);
  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START_BIT, TRANSMIT_DATA, STOP_BIT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       data_count_q;
  logic [7:0]       shift_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             bit_done, push, pop;

  assign bit_done = (cnt_q == CNT_LAST);
  assign push     = Load_data && !Full;
  // A pop happens when a frame may start: from idle, or right at the end of a stop bit.
  assign pop      = Enable && !Empty &&
                    ((state_q == IDLE) || ((state_q == STOP_BIT) && bit_done));

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push)
      count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge Clock_50) begin
    if (push)
      mem_q[wr_ptr_q] <= TX_data;
  end

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_count_q <= '0;
      shift_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      Full         <= 1'b0;
      Empty        <= 1'b1;
      Busy         <= 1'b0;
      Overflow     <= 1'b0;
      UART_TX_O    <= 1'b1;
    end else begin
      count_q <= count_d;
      Full    <= (count_d == OCC_FULL);
      Empty   <= (count_d == '0);
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (Load_data && Full)
        Overflow <= 1'b1;

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          UART_TX_O <= 1'b1;
          Busy      <= 1'b0;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            UART_TX_O <= 1'b0;
            Busy      <= 1'b1;
            state_q   <= START_BIT;
          end
        end

        START_BIT: begin
          if (bit_done) begin
            cnt_q        <= '0;
            UART_TX_O    <= shift_q[0];
            data_count_q <= '0;
            state_q      <= TRANSMIT_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        TRANSMIT_DATA: begin
          if (bit_done) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (data_count_q == 3'd7) begin
              UART_TX_O <= 1'b1;
              state_q   <= STOP_BIT;
            end else begin
              UART_TX_O    <= shift_q[1];
              data_count_q <= data_count_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP_BIT: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q   <= mem_q[rd_ptr_q];
              UART_TX_O <= 1'b0;
              state_q   <= START_BIT;
            end else begin
              Busy    <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmit_controller.sv
// Directed bench for uart_transmit_controller at CLOCK_RATE=6, FIFO_DEPTH=4.
// Every cycle of each frame is compared against the expected 8N1 bit pattern.
module tb_uart_transmit_controller;

  localparam int CR = 6;

  logic       clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       Enable = 1'b0;
  logic       Load_data = 1'b0;
  logic [7:0] TX_data = 8'h00;
  logic       Full, Empty, Busy, Overflow, UART_TX_O;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] pend [$];

  uart_transmit_controller #(.CLOCK_RATE(CR), .FIFO_DEPTH(4)) dut (
    .Clock_50  (clk),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .Load_data (Load_data),
    .TX_data   (TX_data),
    .Full      (Full),
    .Empty     (Empty),
    .Busy      (Busy),
    .Overflow  (Overflow),
    .UART_TX_O (UART_TX_O)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge; afterwards, apply the next pending load (or release the strobe).
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend.size() > 0) begin
      Load_data = 1'b1;
      TX_data   = pend.pop_front();
    end else begin
      Load_data = 1'b0;
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input int first, input int last, input int drop_en_at);
    logic exp_bit;
    int   idx;
    for (int cyc = first; cyc < last; cyc++) begin
      tick();
      if (cyc == drop_en_at)
        Enable = 1'b0;
      idx = cyc / CR;
      if (idx == 0)      exp_bit = 1'b0;
      else if (idx == 9) exp_bit = 1'b1;
      else               exp_bit = b[idx-1];
      check_eq($sformatf("tx[%02h c%0d]", b, cyc), 32'(UART_TX_O), 32'(exp_bit));
      check_eq($sformatf("busy[%02h c%0d]", b, cyc), 32'(Busy), 32'd1);
    end
    $display("frame 0x%02h cycles %0d..%0d checked", b, first, last - 1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_eq("rst_tx", 32'(UART_TX_O), 32'd1);
    check_eq("rst_full", 32'(Full), 32'd0);
    check_eq("rst_empty", 32'(Empty), 32'd1);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_ovf", 32'(Overflow), 32'd0);
    Resetn = 1'b1;
    Enable = 1'b1;
    tick();

    // Single frame 0xA5 with one-cycle latency
    Load_data = 1'b1; TX_data = 8'hA5;
    tick();
    check_eq("a5_tx_load", 32'(UART_TX_O), 32'd1);
    check_eq("a5_empty_load", 32'(Empty), 32'd0);
    expect_frame(8'hA5, 0, 1, -1);
    check_eq("a5_empty_pop", 32'(Empty), 32'd1);
    expect_frame(8'hA5, 1, 60, -1);
    tick();
    check_eq("a5_busy_end", 32'(Busy), 32'd0);
    check_eq("a5_tx_end", 32'(UART_TX_O), 32'd1);

    // Back-to-back 0x00 then 0xFF
    Load_data = 1'b1; TX_data = 8'h00; pend.push_back(8'hFF);
    tick();
    expect_frame(8'h00, 0, 60, -1);
    expect_frame(8'hFF, 0, 60, -1);
    tick();
    check_eq("b2b_busy_end", 32'(Busy), 32'd0);
    check_eq("b2b_empty_end", 32'(Empty), 32'd1);

    // Fill with Enable low, overflow on the fifth byte
    Enable = 1'b0;
    Load_data = 1'b1; TX_data = 8'h11;
    pend.push_back(8'h22); pend.push_back(8'h33); pend.push_back(8'h44); pend.push_back(8'h55);
    tick(); tick(); tick(); tick();
    check_eq("fill_full", 32'(Full), 32'd1);
    check_eq("fill_ovf0", 32'(Overflow), 32'd0);
    tick();
    check_eq("ovf_set", 32'(Overflow), 32'd1);
    check_eq("ovf_full", 32'(Full), 32'd1);
    check_eq("ovf_tx_idle", 32'(UART_TX_O), 32'd1);
    check_eq("ovf_busy", 32'(Busy), 32'd0);
    Enable = 1'b1;
    expect_frame(8'h11, 0, 60, -1);
    expect_frame(8'h22, 0, 60, -1);
    expect_frame(8'h33, 0, 60, -1);
    expect_frame(8'h44, 0, 60, -1);
    tick();
    check_eq("drain_busy", 32'(Busy), 32'd0);
    check_eq("drain_empty", 32'(Empty), 32'd1);
    check_eq("drain_ovf_sticky", 32'(Overflow), 32'd1);

    // Enable dropped mid-frame with one byte queued
    Load_data = 1'b1; TX_data = 8'h3C; pend.push_back(8'h5A);
    tick();
    expect_frame(8'h3C, 0, 60, 20);
    for (int i = 0; i < 12; i++) tick();
    check_eq("hold_tx", 32'(UART_TX_O), 32'd1);
    check_eq("hold_busy", 32'(Busy), 32'd0);
    check_eq("hold_empty", 32'(Empty), 32'd0);
    Enable = 1'b1;
    expect_frame(8'h5A, 0, 60, -1);
    tick();
    check_eq("reen_busy", 32'(Busy), 32'd0);
    check_eq("reen_ovf", 32'(Overflow), 32'd1);

    // Reset mid-frame with a byte still queued
    Load_data = 1'b1; TX_data = 8'h96; pend.push_back(8'h77);
    tick();
    expect_frame(8'h96, 0, 25, -1);
    Resetn = 1'b0;
    tick();
    check_eq("mrst_tx", 32'(UART_TX_O), 32'd1);
    check_eq("mrst_empty", 32'(Empty), 32'd1);
    check_eq("mrst_busy", 32'(Busy), 32'd0);
    check_eq("mrst_ovf", 32'(Overflow), 32'd0);
    check_eq("mrst_full", 32'(Full), 32'd0);
    Resetn = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      check_eq($sformatf("post_rst_tx c%0d", i), 32'(UART_TX_O), 32'd1);
    end
    check_eq("post_rst_busy", 32'(Busy), 32'd0);
    $display("reset mid-frame checked");

    // Simultaneous push/pop with 3 queued, then wrap the pointers
    Enable = 1'b0;
    Load_data = 1'b1; TX_data = 8'hA1; pend.push_back(8'hA2); pend.push_back(8'hA3);
    tick(); tick(); tick();
    check_eq("wrap_three_full", 32'(Full), 32'd0);
    Enable = 1'b1;
    Load_data = 1'b1; TX_data = 8'hA4; pend.push_back(8'hA5);
    tick();
    check_eq("pp_tx", 32'(UART_TX_O), 32'd0);
    check_eq("pp_full", 32'(Full), 32'd0);
    check_eq("pp_empty", 32'(Empty), 32'd0);
    check_eq("pp_ovf", 32'(Overflow), 32'd0);
    tick();
    check_eq("wrap_full", 32'(Full), 32'd1);
    check_eq("wrap_tx", 32'(UART_TX_O), 32'd0);
    check_eq("wrap_ovf", 32'(Overflow), 32'd0);
    expect_frame(8'hA1, 2, 60, -1);
    expect_frame(8'hA2, 0, 60, -1);
    expect_frame(8'hA3, 0, 60, -1);
    expect_frame(8'hA4, 0, 60, -1);
    expect_frame(8'hA5, 0, 60, -1);
    tick();
    check_eq("wrap_busy_end", 32'(Busy), 32'd0);
    check_eq("wrap_empty_end", 32'(Empty), 32'd1);
    check_eq("wrap_ovf_end", 32'(Overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
